// File: rtl/ras_ckpt_pred_pkg.sv
// Shared types and sizing for the return-address stack and its compact checkpoint.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// The stack is sized here once; RAS_DEPTH must stay equal to 2**RAS_W so that
// pointer arithmetic wraps for free.
package ras_pkg;

    localparam int XLEN      = 32;
    localparam int RAS_W     = 4;
    localparam int RAS_DEPTH = 16;
    localparam int CNT_W     = 2;
    localparam int STAT_W    = 16;

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [RAS_W:0]   DEPTH_MAX = (RAS_W+1)'(RAS_DEPTH);

    // One stack slot: return address plus recursion count of repeated pushes.
    typedef struct packed {
        logic [XLEN-1:0]  addr;
        logic [CNT_W-1:0] cnt;
    } entry_t;

    // What travels down the pipe with each instruction.
    typedef struct packed {
        logic [RAS_W-1:0] sp;
        logic [RAS_W:0]   depth;
        logic [XLEN-1:0]  tos;
        logic [CNT_W-1:0] cnt;
    } ckpt_t;

endpackage

// File: rtl/ras_ckpt_pred_if.sv
// Fetch/execute-side signal bundle of the return-address stack predictor.
// Latency: n/a (wiring only).
// Backpressure: none; f_allow_in gates fetch-side ops, e_recover overrides them.
// Ports: fetch op request (f_*), prediction and post-op checkpoint outputs,
// execute-stage recovery (e_*), saturating statistics.
interface ras_ckpt_pred_if;
    import ras_pkg::*;

    logic             f_allow_in;
    logic             f_push;
    logic             f_pop;
    logic [XLEN-1:0]  f_push_addr;
    logic             f_pred_ret_valid;
    logic [XLEN-1:0]  f_pred_ret_pc;
    logic [RAS_W-1:0] f_ckpt_sp;
    logic [RAS_W:0]   f_ckpt_depth;
    logic [XLEN-1:0]  f_ckpt_tos;
    logic [CNT_W-1:0] f_ckpt_cnt;
    logic             e_recover;
    logic [RAS_W-1:0] e_ckpt_sp;
    logic [RAS_W:0]   e_ckpt_depth;
    logic [XLEN-1:0]  e_ckpt_tos;
    logic [CNT_W-1:0] e_ckpt_cnt;
    logic [STAT_W-1:0] stat_overflow;
    logic [STAT_W-1:0] stat_underflow;

    modport master (
        output f_allow_in, f_push, f_pop, f_push_addr,
        output e_recover, e_ckpt_sp, e_ckpt_depth, e_ckpt_tos, e_ckpt_cnt,
        input  f_pred_ret_valid, f_pred_ret_pc,
        input  f_ckpt_sp, f_ckpt_depth, f_ckpt_tos, f_ckpt_cnt,
        input  stat_overflow, stat_underflow
    );

    modport slave (
        input  f_allow_in, f_push, f_pop, f_push_addr,
        input  e_recover, e_ckpt_sp, e_ckpt_depth, e_ckpt_tos, e_ckpt_cnt,
        output f_pred_ret_valid, f_pred_ret_pc,
        output f_ckpt_sp, f_ckpt_depth, f_ckpt_tos, f_ckpt_cnt,
        output stat_overflow, stat_underflow
    );

endinterface

// File: rtl/ras_ckpt_pred_next_state.sv
// Pop-then-push next-state function of the return-address stack.
// Latency: purely combinational.
// Backpressure: none; caller gates push/pop when the op must not apply.
// Ports: current sp/depth, TOS and the entry below it; push/pop/addr request;
// next sp/depth/TOS, two memory write strobes, overflow/underflow events.
module ras_next_state
    import ras_pkg::*;
(
    input  logic [RAS_W-1:0] sp,
    input  logic [RAS_W:0]   depth,
    input  entry_t           tos,
    input  entry_t           below,
    input  logic             push,
    input  logic             pop,
    input  logic [XLEN-1:0]  addr,
    output logic [RAS_W-1:0] n_sp,
    output logic [RAS_W:0]   n_depth,
    output entry_t           n_tos,
    output logic             pop_wr,     // write pop_wr_dat to mem[sp]
    output entry_t           pop_wr_dat,
    output logic             push_wr,    // write n_tos to mem[n_sp]
    output logic             overflow,
    output logic             underflow
);

    logic [RAS_W-1:0] p_sp;
    logic [RAS_W:0]   p_depth;
    entry_t           p_tos;

    always_comb begin
        p_sp      = sp;
        p_depth   = depth;
        p_tos     = tos;
        pop_wr    = 1'b0;
        underflow = 1'b0;
        if (pop) begin
            if (depth == '0) begin
                underflow = 1'b1;
            end else if (tos.cnt != '0) begin
                // Recursive return: consume one repetition, slot stays.
                p_tos.cnt = tos.cnt - 1'b1;
                pop_wr    = 1'b1;
            end else begin
                p_sp    = sp - 1'b1;
                p_depth = depth - 1'b1;
                p_tos   = below;
            end
        end

        n_sp     = p_sp;
        n_depth  = p_depth;
        n_tos    = p_tos;
        push_wr  = 1'b0;
        overflow = 1'b0;
        if (push) begin
            push_wr = 1'b1;
            if (p_depth != '0 && p_tos.addr == addr && p_tos.cnt != CNT_MAX) begin
                n_tos.cnt = p_tos.cnt + 1'b1;
            end else begin
                n_sp       = p_sp + 1'b1;
                n_tos.addr = addr;
                n_tos.cnt  = '0;
                // Full stack: the wrap overwrites the oldest slot, depth stays.
                if (p_depth == DEPTH_MAX) overflow = 1'b1;
                else                      n_depth  = p_depth + 1'b1;
            end
        end
        // pop_wr only fires when sp did not move, so p_tos still belongs at sp.
        pop_wr_dat = p_tos;
    end

endmodule

// File: rtl/ras_ckpt_pred.sv
// Return-address stack with compact {sp, depth, TOS} checkpoint and 1-cycle recovery.
// Latency: prediction and checkpoint are combinational; updates land at the next edge.
// Backpressure: ops apply only with f_allow_in=1; e_recover discards the fetch op.
// Ports: clk, rst (sync, active high), io (slave side of ras_ckpt_pred_if).
module ras_ckpt_pred
    import ras_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    ras_ckpt_pred_if.slave io
);

    entry_t            mem [RAS_DEPTH];
    logic [RAS_W-1:0]  sp;
    logic [RAS_W:0]    depth;
    logic [STAT_W-1:0] stat_ovf;
    logic [STAT_W-1:0] stat_unf;

    logic             op_en;
    logic [RAS_W-1:0] sp_m1;
    entry_t           tos;
    entry_t           below;
    logic [RAS_W-1:0] n_sp;
    logic [RAS_W:0]   n_depth;
    entry_t           n_tos;
    logic             pop_wr;
    entry_t           pop_wr_dat;
    logic             push_wr;
    logic             ovf_evt;
    logic             unf_evt;
    ckpt_t            f_ckpt;
    ckpt_t            e_ckpt;

    assign op_en = !rst && io.f_allow_in && !io.e_recover;
    assign sp_m1 = sp - 1'b1;
    assign tos   = mem[sp];
    assign below = mem[sp_m1];

    ras_next_state u_next (
        .sp         (sp),
        .depth      (depth),
        .tos        (tos),
        .below      (below),
        .push       (io.f_push && op_en),
        .pop        (io.f_pop && op_en),
        .addr       (io.f_push_addr),
        .n_sp       (n_sp),
        .n_depth    (n_depth),
        .n_tos      (n_tos),
        .pop_wr     (pop_wr),
        .pop_wr_dat (pop_wr_dat),
        .push_wr    (push_wr),
        .overflow   (ovf_evt),
        .underflow  (unf_evt)
    );

    // Prediction comes from the pre-update state so a return predicts this cycle.
    assign io.f_pred_ret_valid = (depth != '0);
    assign io.f_pred_ret_pc    = (depth != '0) ? tos.addr : '0;

    // An empty checkpoint carries a zero TOS; recovery ignores it anyway.
    assign f_ckpt.sp    = n_sp;
    assign f_ckpt.depth = n_depth;
    assign f_ckpt.tos   = (n_depth != '0) ? n_tos.addr : '0;
    assign f_ckpt.cnt   = (n_depth != '0) ? n_tos.cnt  : '0;

    assign io.f_ckpt_sp    = f_ckpt.sp;
    assign io.f_ckpt_depth = f_ckpt.depth;
    assign io.f_ckpt_tos   = f_ckpt.tos;
    assign io.f_ckpt_cnt   = f_ckpt.cnt;

    assign e_ckpt = '{sp: io.e_ckpt_sp, depth: io.e_ckpt_depth,
                      tos: io.e_ckpt_tos, cnt: io.e_ckpt_cnt};

    assign io.stat_overflow  = stat_ovf;
    assign io.stat_underflow = stat_unf;

    always_ff @(posedge clk) begin
        if (rst) begin
            sp       <= '0;
            depth    <= '0;
            stat_ovf <= '0;
            stat_unf <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) mem[i] <= '0;
        end else if (io.e_recover) begin
            // Only the TOS slot is restored; deeper wrong-path damage is tolerated.
            sp    <= e_ckpt.sp;
            depth <= (e_ckpt.depth > DEPTH_MAX) ? DEPTH_MAX : e_ckpt.depth;
            if (e_ckpt.depth != '0)
                mem[e_ckpt.sp] <= '{addr: e_ckpt.tos, cnt: e_ckpt.cnt};
        end else if (io.f_allow_in) begin
            sp    <= n_sp;
            depth <= n_depth;
            if (pop_wr)  mem[sp]   <= pop_wr_dat;
            // Later write wins when a pop-decrement and compression hit the same slot.
            if (push_wr) mem[n_sp] <= n_tos;
            if (ovf_evt && stat_ovf != '1) stat_ovf <= stat_ovf + 1'b1;
            if (unf_evt && stat_unf != '1) stat_unf <= stat_unf + 1'b1;
        end
    end

endmodule

// File: tb/tb_ras_ckpt_pred.sv
// Directed bench for ras_ckpt_pred with an expectation queue and a negedge monitor.
// Latency: n/a.
// Backpressure: n/a.
module tb_ras_ckpt_pred;
    import ras_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ras_ckpt_pred_if io ();

    ras_ckpt_pred dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    typedef enum int {F_VLD, F_PC, F_SP, F_DEPTH, F_TOS, F_CNT, F_OVF, F_UNF} fld_e;
    typedef struct {
        int          cyc;
        fld_e        fld;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] field_val(input fld_e f);
        case (f)
            F_VLD:   return 32'(io.f_pred_ret_valid);
            F_PC:    return 32'(io.f_pred_ret_pc);
            F_SP:    return 32'(io.f_ckpt_sp);
            F_DEPTH: return 32'(io.f_ckpt_depth);
            F_TOS:   return 32'(io.f_ckpt_tos);
            F_CNT:   return 32'(io.f_ckpt_cnt);
            F_OVF:   return 32'(io.stat_overflow);
            default: return 32'(io.stat_underflow);
        endcase
    endfunction

    // Monitor: compares every expectation tagged with the current cycle.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t        e;
            logic [31:0] act;
            e   = q.pop_front();
            act = field_val(e.fld);
            checks++;
            if (e.cyc != cyc) begin
                errors++;
                $display("FAIL %s missed sample: tagged cycle %0d seen at cycle %0d", e.name, e.cyc, cyc);
            end else if (act !== e.val) begin
                errors++;
                $display("FAIL %s cycle %0d actual 0x%0h expected 0x%0h", e.name, cyc, act, e.val);
            end
        end
    end

    task automatic drive(input logic a, input logic pu, input logic po, input logic [31:0] ad);
        io.f_allow_in  = a;
        io.f_push      = pu;
        io.f_pop       = po;
        io.f_push_addr = ad;
    endtask

    task automatic ex(input fld_e f, input logic [31:0] v, input string n);
        q.push_back('{cyc: cyc, fld: f, val: v, name: n});
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic recover(input logic [3:0] s, input logic [4:0] d, input logic [31:0] t, input logic [1:0] c);
        io.e_recover    = 1'b1;
        io.e_ckpt_sp    = s;
        io.e_ckpt_depth = d;
        io.e_ckpt_tos   = t;
        io.e_ckpt_cnt   = c;
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        recover(4'd0, 5'd0, 32'h0, 2'd0);
        io.e_recover = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        ex(F_VLD, 0, "rst_vld"); ex(F_PC, 0, "rst_pc"); ex(F_SP, 0, "rst_sp");
        ex(F_DEPTH, 0, "rst_depth"); ex(F_TOS, 0, "rst_tos"); ex(F_CNT, 0, "rst_cnt");
        ex(F_OVF, 0, "rst_ovf"); ex(F_UNF, 0, "rst_unf");
        tick();

        // Basic push/pop and underflow
        drive(1'b1, 1'b1, 1'b0, 32'h100);
        ex(F_VLD, 0, "t1_push1_vld"); ex(F_SP, 1, "t1_push1_sp"); ex(F_DEPTH, 1, "t1_push1_depth");
        ex(F_TOS, 32'h100, "t1_push1_tos"); ex(F_CNT, 0, "t1_push1_cnt");
        tick();
        drive(1'b1, 1'b1, 1'b0, 32'h200);
        ex(F_VLD, 1, "t1_push2_vld"); ex(F_PC, 32'h100, "t1_push2_pc");
        ex(F_DEPTH, 2, "t1_push2_depth"); ex(F_TOS, 32'h200, "t1_push2_tos");
        tick();
        drive(1'b1, 1'b0, 1'b1, 32'h0);
        ex(F_PC, 32'h200, "t1_pop1_pc"); ex(F_DEPTH, 1, "t1_pop1_depth"); ex(F_TOS, 32'h100, "t1_pop1_tos");
        tick();
        ex(F_PC, 32'h100, "t1_pop2_pc"); ex(F_DEPTH, 0, "t1_pop2_depth");
        tick();
        ex(F_VLD, 0, "t1_pop3_vld"); ex(F_PC, 0, "t1_pop3_pc");
        tick();
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        ex(F_UNF, 1, "t1_unf"); ex(F_DEPTH, 0, "t1_idle_depth");
        tick();

        // Recursion compression up to CNT_MAX
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 1'b0, 32'h300);
            tick();
        end
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        ex(F_DEPTH, 1, "t2_depth4"); ex(F_CNT, 3, "t2_cnt4"); ex(F_TOS, 32'h300, "t2_tos4"); ex(F_SP, 1, "t2_sp4");
        tick();
        drive(1'b1, 1'b1, 1'b0, 32'h300);
        ex(F_DEPTH, 2, "t2_depth5"); ex(F_SP, 2, "t2_sp5"); ex(F_CNT, 0, "t2_cnt5");
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 1'b1, 32'h0);
            ex(F_VLD, 1, "t2_pop_vld"); ex(F_PC, 32'h300, "t2_pop_pc");
            ex(F_DEPTH, (i < 4) ? 32'd1 : 32'd0, "t2_pop_depth");
            if (i < 4) ex(F_CNT, 32'(3 - i), "t2_pop_cnt");
            tick();
        end
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        ex(F_VLD, 0, "t2_empty_vld"); ex(F_UNF, 1, "t2_unf");
        tick();

        // Overflow by wrap, then drain
        for (int i = 1; i <= 17; i++) begin
            drive(1'b1, 1'b1, 1'b0, 32'h1000 + 32'(4 * i));
            if (i == 16) ex(F_DEPTH, 16, "t3_depth16");
            if (i == 17) begin
                ex(F_DEPTH, 16, "t3_depth17"); ex(F_SP, 1, "t3_sp17");
            end
            tick();
        end
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        ex(F_OVF, 1, "t3_ovf"); ex(F_PC, 32'h1044, "t3_top");
        tick();
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b0, 1'b1, 32'h0);
            ex(F_PC, 32'h1000 + 32'(4 * (17 - i)), "t3_pop_pc");
            tick();
        end
        ex(F_VLD, 0, "t3_pop17_vld");
        tick();
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        ex(F_UNF, 2, "t3_unf");
        tick();

        // Coroutine: push and pop together
        drive(1'b1, 1'b1, 1'b0, 32'h100);
        ex(F_SP, 2, "t4_push_sp"); ex(F_DEPTH, 1, "t4_push_depth");
        tick();
        drive(1'b1, 1'b1, 1'b1, 32'h500);
        ex(F_VLD, 1, "t4_co_vld"); ex(F_PC, 32'h100, "t4_co_pc"); ex(F_TOS, 32'h500, "t4_co_tos");
        ex(F_DEPTH, 1, "t4_co_depth"); ex(F_SP, 2, "t4_co_sp");
        tick();
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        ex(F_PC, 32'h500, "t4_after_pc"); ex(F_DEPTH, 1, "t4_after_depth");
        tick();
        drive(1'b1, 1'b0, 1'b1, 32'h0);
        ex(F_DEPTH, 0, "t4_pop_depth"); ex(F_SP, 1, "t4_pop_sp");
        tick();

        // Checkpoint capture and recovery over a wrong path
        drive(1'b1, 1'b1, 1'b0, 32'h100);
        ex(F_SP, 2, "t5_ck_sp"); ex(F_DEPTH, 1, "t5_ck_depth"); ex(F_TOS, 32'h100, "t5_ck_tos"); ex(F_CNT, 0, "t5_ck_cnt");
        tick();
        drive(1'b1, 1'b1, 1'b0, 32'h200); tick();
        drive(1'b1, 1'b0, 1'b1, 32'h0);   tick();
        drive(1'b1, 1'b0, 1'b1, 32'h0);   tick();
        drive(1'b1, 1'b1, 1'b0, 32'h900);
        ex(F_SP, 2, "t5_wp_sp"); ex(F_TOS, 32'h900, "t5_wp_tos");
        tick();
        drive(1'b1, 1'b1, 1'b0, 32'h777);
        recover(4'd2, 5'd1, 32'h100, 2'd0);
        tick();
        io.e_recover = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        ex(F_VLD, 1, "t5_rec_vld"); ex(F_PC, 32'h100, "t5_rec_pc"); ex(F_DEPTH, 1, "t5_rec_depth");
        ex(F_SP, 2, "t5_rec_sp"); ex(F_OVF, 1, "t5_rec_ovf"); ex(F_UNF, 2, "t5_rec_unf");
        tick();
        drive(1'b1, 1'b0, 1'b1, 32'h0);
        ex(F_PC, 32'h100, "t5_pop_pc"); ex(F_DEPTH, 0, "t5_pop_depth");
        tick();

        // Recovery clamps an out-of-range depth
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        recover(4'd7, 5'd20, 32'hABC, 2'd1);
        tick();
        io.e_recover = 1'b0;
        ex(F_DEPTH, 16, "t5_clamp_depth"); ex(F_PC, 32'hABC, "t5_clamp_pc");
        ex(F_CNT, 1, "t5_clamp_cnt"); ex(F_SP, 7, "t5_clamp_sp");
        tick();

        // Stall holds state; reset mid-operation clears everything
        drive(1'b0, 1'b1, 1'b0, 32'h444);
        ex(F_DEPTH, 16, "t6_stall_depth"); ex(F_SP, 7, "t6_stall_sp"); ex(F_TOS, 32'hABC, "t6_stall_tos");
        tick();
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        ex(F_PC, 32'hABC, "t6_hold_pc"); ex(F_DEPTH, 16, "t6_hold_depth");
        tick();
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 32'h555);
        tick();
        rst = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        ex(F_VLD, 0, "t6_rst_vld"); ex(F_PC, 0, "t6_rst_pc"); ex(F_OVF, 0, "t6_rst_ovf");
        ex(F_UNF, 0, "t6_rst_unf"); ex(F_DEPTH, 0, "t6_rst_depth"); ex(F_SP, 0, "t6_rst_sp");
        tick();

        repeat (2) tick();
        if (q.size() != 0) begin
            errors += q.size();
            $display("FAIL drain %0d expectations never sampled", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ras_ckpt_pred.md
Name: ras_ckpt_pred

Overview:
Parametrised return-address stack for the fetch-stage PC predictor. It is a successor to the full-snapshot RAS.
- Circular stack with per-entry recursion counters.
- Compact checkpoint: pointer, depth, top-of-stack entry. Replaces the RAS_DEPTH*32-bit snapshot.
- Single-cycle recovery on an execute-stage redirect.
- Saturating overflow and underflow statistics.
Sits beside the gshare/local/BTB logic. The fetch stage consumes f_pred_ret_pc; the checkpoint travels down the pipe with the instruction.

Parameters:
XLEN, 32, address width
RAS_DEPTH, 16, entries; must equal 2**RAS_W
RAS_W, 4, stack pointer width
CNT_W, 2, recursion counter width per entry
STAT_W, 16, statistics counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
f_allow_in  in  1  fetch advances; stack ops apply only when 1
f_push  in  1  fetched instr is a call
f_pop  in  1  fetched instr is a return
f_push_addr  in  XLEN  return address (pc+4) to push
f_pred_ret_valid  out  1  stack non-empty (depth>0)
f_pred_ret_pc  out  XLEN  current TOS address; 0 when empty
f_ckpt_sp  out  RAS_W  post-op stack pointer
f_ckpt_depth  out  RAS_W+1  post-op depth
f_ckpt_tos  out  XLEN  post-op TOS address
f_ckpt_cnt  out  CNT_W  post-op TOS counter
e_recover  in  1  execute mispredict redirect; restore checkpoint
e_ckpt_sp  in  RAS_W  checkpoint pointer
e_ckpt_depth  in  RAS_W+1  checkpoint depth
e_ckpt_tos  in  XLEN  checkpoint TOS address
e_ckpt_cnt  in  CNT_W  checkpoint TOS counter
stat_overflow  out  STAT_W  pushes that evicted the oldest entry
stat_underflow  out  STAT_W  pops on an empty stack

Behaviour:
- State:
  - mem[RAS_DEPTH] of {addr, cnt}.
  - sp: index of TOS.
  - depth: 0..RAS_DEPTH.
  - Two stat counters.
- Reset (rst=1):
  - sp=0, depth=0, every mem entry = {0,0}, stats=0.
  - Outputs: f_pred_ret_valid=0, f_pred_ret_pc=0, ckpt outputs all 0.
  - rst has priority over every other input. Reset mid-operation discards in-flight ops.
- f_pred_ret_pc and f_pred_ret_valid are combinational from pre-update state, so a return predicts in the same cycle with zero latency.
- Op applies at the clock edge when f_allow_in=1 and e_recover=0. Pointer arithmetic is modulo RAS_DEPTH.
- Pop, evaluated first:
  - depth==0: stat_underflow++, no state change.
  - TOS cnt>0: cnt-1.
  - Otherwise: sp-1, depth-1.
- Push, evaluated on the state left by pop:
  - Compression: if depth>0, f_push_addr==TOS addr and TOS cnt != all-ones, then cnt+1 with sp and depth unchanged.
  - Otherwise: sp+1, mem[sp+1]={f_push_addr,0}, depth=min(depth+1,RAS_DEPTH).
  - If depth was already RAS_DEPTH, the oldest entry is overwritten by wrap and stat_overflow++.
- Push and pop in the same cycle (coroutine): pop rule, then push rule, within one cycle. Prediction is the old TOS.
- Neither push nor pop, or f_allow_in=0: state holds.
- Checkpoint outputs are combinational and show the state after this cycle's op. With no op or f_allow_in=0 they show the current state.
- e_recover=1:
  - Overrides any simultaneous fetch op; that op is discarded and stats are unchanged.
  - sp=e_ckpt_sp and depth=min(e_ckpt_depth, RAS_DEPTH).
  - If e_ckpt_depth>0: mem[e_ckpt_sp]={e_ckpt_tos, e_ckpt_cnt}.
  - Restored state is visible the next cycle.
  - Deeper entries are not restored; wrong-path corruption of them is accepted.
- Stat counters saturate at all-ones.

Decomposition:
- Shared package ras_pkg:
  - entry struct {addr[XLEN], cnt[CNT_W]}.
  - checkpoint struct {sp, depth, tos, cnt}.
  - CNT_MAX constant.
- One sub-module, ras_next_state: pure combinational pop-then-push next-state function.
  - Takes current sp, depth and TOS entry, plus push, pop and addr.
  - Drives both the checkpoint outputs and the register update.
  - The top level holds the registers, the recovery mux and the stats.

Test Plan:
- Reset; push 0x100, push 0x200; pop, pop, pop -> pred 0x200, then 0x100, then valid=0 and stat_underflow=1.
- CNT_W=2: push 0x300 x4 -> depth=1, cnt=3. 5th push -> depth=2. Five pops each return 0x300, then valid=0.
- RAS_DEPTH=16: push 17 distinct addrs A1..A17 -> stat_overflow=1, depth=16. 16 pops return A17..A2; 17th pop -> stat_underflow=1.
- Stack [0x100]; push and pop together with 0x500 -> pred 0x100 that cycle. Next cycle: TOS=0x500, depth=1.
- Sequence:
  - push 0x100 and capture ckpt {sp=1, depth=1, tos=0x100, cnt=0}.
  - push 0x200, pop, pop, push 0x900.
  - Assert e_recover with the captured ckpt while f_push=1 (addr 0x777).
  - Next cycle -> pred 0x100, depth=1; 0x777 not pushed.
- f_allow_in=0 with f_push=1 -> state unchanged. Assert rst with depth=3 -> next cycle valid=0, stats=0.
